// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: default operand width and state encoding.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell used as the bit-slice datapath of the serial adder.
module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: processes one bit per clock through a single full-adder cell,
// LSB first, and publishes sum/cout/overflow when the last bit is done.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned            CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]       LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               load_c, shift_c, last_c;

  logic [WIDTH-1:0]   a_q, b_q;
  logic               carry_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q, ovf_q;
  logic               fa_s, fa_co;

  // ---------------- Controller ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
    last_c  = (cnt_q == LAST_BIT);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_c = 1'b1;
        if (last_c) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || load_c) cnt_q <= '0;
    else if (shift_c)    cnt_q <= cnt_q + CNT_W'(1);
  end

  // ---------------- Datapath ----------------
  serial_adder_fa u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_co)
  );

  // Operand A register doubles as the result shift register: sum bits enter at the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
    end else if (load_c) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
    end else if (shift_c) begin
      a_q     <= {fa_s, a_q[WIDTH-1:1]};
      b_q     <= {1'b0, b_q[WIDTH-1:1]};
      carry_q <= fa_co;
    end
  end

  // On the last bit, carry_q is the carry into the MSB and fa_co the carry out of it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (shift_c && last_c) begin
      sum_q  <= {fa_s, a_q[WIDTH-1:1]};
      cout_q <= fa_co;
      ovf_q  <= carry_q ^ fa_co;
    end
  end

  assign ready    = (state_q != ST_SHIFT);
  assign busy     = (state_q == ST_SHIFT);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases, mid-operation start
// and reset, then a long back-to-back random run against an arithmetic reference.
module tb_serial_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned LAT = W + 1;
  localparam int unsigned NV  = 1000;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         ready, busy, done, cout, overflow;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, cout, sum} from plain integer arithmetic and the signed-sign rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] t;
    logic       ovf;
    t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    ovf = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {ovf, t};
  endfunction

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input int glitch_at, input int reset_at);
    logic [W+1:0] exp;
    int           edges;
    bit           seen;
    exp = model(av, bv, cv);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_after_accept", 32'(ready), 32'd0);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < int'(W) + 4) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
      if (reset_at > 0 && edges == reset_at + 1) begin
        reset = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        return;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        chk("busy_in_shift", 32'(busy), 32'd1);
        if (edges == glitch_at) begin
          start = 1'b1;
          a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        if (edges == reset_at) reset = 1'b1;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(edges), 32'(W));
    chk("sum", 32'(sum), 32'(exp[W-1:0]));
    chk("cout", 32'(cout), 32'(exp[W]));
    chk("overflow", 32'(overflow), 32'(exp[W+1]));
    chk("ready_in_done", 32'(ready), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_single", 32'(done), 32'd0);
    chk("sum_held", 32'(sum), 32'(exp[W-1:0]));
  endtask

  initial begin
    logic [W+1:0] q[$];
    logic [W+1:0] e;
    logic [W-1:0] ra, rb;
    logic         rc;

    reset = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    chk("start_in_reset_ignored", 32'(busy), 32'd0);

    run_op(16'h0001, 16'h0001, 1'b0, -1, -1);
    run_op(16'hFFFF, 16'h0001, 1'b0, -1, -1);
    run_op(16'h7FFF, 16'h0001, 1'b0, -1, -1);
    run_op(16'h8000, 16'h8000, 1'b1, -1, -1);
    run_op(16'h0F0F, 16'h1111, 1'b1, 5, -1);
    run_op(16'hABCD, 16'h1357, 1'b0, -1, 8);
    repeat (20) begin
      @(negedge clk);
      chk("no_done_after_reset", 32'(done), 32'd0);
    end
    run_op(16'h1234, 16'h4321, 1'b0, -1, -1);

    // Back-to-back: start held high, operands re-randomised every cycle.
    @(negedge clk);
    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
    a = ra; b = rb; cin = rc; start = 1'b1;
    q.push_back(model(ra, rb, rc));
    for (int k = 0; k < int'(NV * LAT); k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k % int'(LAT) == int'(LAT) - 1) begin
        chk("b2b_done", 32'(done), 32'd1);
        e = q.pop_front();
        chk("b2b_sum", 32'(sum), 32'(e[W-1:0]));
        chk("b2b_cout", 32'(cout), 32'(e[W]));
        chk("b2b_ovf", 32'(overflow), 32'(e[W+1]));
      end else begin
        chk("b2b_no_done", 32'(done), 32'd0);
      end
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      a = ra; b = rb; cin = rc;
      if (k + 1 >= int'(NV * LAT)) start = 1'b0;
      else if ((k + 1) % int'(LAT) == 0) q.push_back(model(ra, rb, rc));
    end
    @(negedge clk);
    chk("idle_after_b2b", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
